// File: rtl/uart_tx_arbiter_if.sv
// Requester/TX-FIFO bundle for uart_tx_arbiter.
// master: arbiter side, slave: requesters + FIFO.
interface uart_tx_arbiter_if #(
    parameter int NumReq       = 2,
    parameter int DataBitsSize = 8
);
    logic [NumReq-1:0]              req_valid;
    logic [NumReq*DataBitsSize-1:0] req_data;
    logic [NumReq-1:0]              req_last;
    logic [NumReq-1:0]              req_ready;
    logic                           fifo_full;
    logic                           fifo_write_req;
    logic [DataBitsSize-1:0]        fifo_data;
    logic [NumReq-1:0]              grant;
    logic                           busy;

    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_write_req, fifo_data,
        output grant, busy
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_write_req, fifo_data,
        input  grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locked arbiter sharing one TX FIFO write port.
// Ports: clk, rst_n (async low), bus (uart_tx_arbiter_if.master).
module uart_tx_arbiter #(
    parameter int NumReq       = 2,
    parameter int DataBitsSize = 8,
    parameter int MaxBurst     = 16,
    parameter int IdleTimeout  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int PW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int BW = $clog2(MaxBurst + 1);
    localparam int IW = $clog2(IdleTimeout + 1);

    localparam logic [PW-1:0] RrInit   = PW'(NumReq - 1);
    localparam logic [BW-1:0] BurstEnd = BW'(MaxBurst - 1);
    localparam logic [IW-1:0] IdleEnd  = IW'(IdleTimeout - 1);

    typedef enum logic [0:0] {
        S_IDLE,
        S_BURST
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PW-1:0]       r_owner;
    logic [PW-1:0]       w_owner_nxt;
    logic [PW-1:0]       r_rr_ptr;
    logic [PW-1:0]       w_rr_nxt;
    logic [NumReq-1:0]   r_grant;
    logic [NumReq-1:0]   w_grant_nxt;
    logic [BW-1:0]       r_burst_cnt;
    logic [BW-1:0]       w_burst_nxt;
    logic [IW-1:0]       r_idle_cnt;
    logic [IW-1:0]       w_idle_nxt;

    logic                w_any;
    logic [PW-1:0]       w_pick;
    logic                w_own_valid;
    logic                w_own_last;
    logic [DataBitsSize-1:0] w_own_data;
    logic                w_beat;
    logic                w_exit;

    // Nearest valid requester strictly after rr_ptr, wrapping.
    always_comb begin
        int            idx;
        logic [PW-1:0] sel;
        w_any  = 1'b0;
        w_pick = r_rr_ptr;
        idx    = 0;
        sel    = '0;
        for (int k = 1; k <= NumReq; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            sel = idx[PW-1:0];
            if (!w_any && bus.req_valid[sel]) begin
                w_any  = 1'b1;
                w_pick = sel;
            end
        end
    end

    // Owner's slice of the request bundle.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (r_owner == PW'(i)) begin
                w_own_valid = bus.req_valid[i];
                w_own_last  = bus.req_last[i];
                w_own_data  =
                    bus.req_data[i*DataBitsSize +: DataBitsSize];
            end
        end
    end

    // Full is sampled in the same cycle, so no write ever hits a full FIFO.
    assign w_beat = (r_state == S_BURST) && w_own_valid &&
                    !bus.fifo_full;

    assign bus.busy           = (r_state == S_BURST);
    assign bus.grant          = r_grant;
    assign bus.fifo_write_req = w_beat;
    assign bus.fifo_data      = w_beat ? w_own_data : '0;
    assign bus.req_ready      =
        ((r_state == S_BURST) && !bus.fifo_full) ? r_grant : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_grant_nxt = r_grant;
        w_burst_nxt = r_burst_cnt;
        w_idle_nxt  = r_idle_cnt;
        w_exit      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_BURST;
                    w_owner_nxt = w_pick;
                    w_grant_nxt = NumReq'(1) << w_pick;
                    w_burst_nxt = '0;
                    w_idle_nxt  = '0;
                end
            end
            S_BURST: begin
                if (w_beat) begin
                    w_idle_nxt = '0;
                    // last and MaxBurst on one beat give a single exit
                    if (w_own_last || r_burst_cnt == BurstEnd) begin
                        w_exit = 1'b1;
                    end else begin
                        w_burst_nxt = r_burst_cnt + 1'b1;
                    end
                end else if (!w_own_valid) begin
                    if (r_idle_cnt == IdleEnd) begin
                        w_exit = 1'b1;
                    end else begin
                        w_idle_nxt = r_idle_cnt + 1'b1;
                    end
                end else begin
                    // stalled on full: owner is still active
                    w_idle_nxt = '0;
                end
                if (w_exit) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = r_owner;
                    w_grant_nxt = '0;
                    w_burst_nxt = '0;
                    w_idle_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= RrInit;
            r_grant     <= '0;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_grant     <= w_grant_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_idle_cnt  <= w_idle_nxt;
        end
    end
endmodule
